// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - sequencer collecting A/B/opcode bytes from uart_rx, driving the ALU
// and handing the result to uart_tx, with parity/timeout/overrun error reporting.
module uart_alu_ctrl #(
  parameter int N_DATA          = 8,
  parameter int PARITY_CHECK    = 1,
  parameter int EVEN_ODD_PARITY = 1,
  parameter int N_OP            = 6,
  parameter int N_TIMEOUT       = 50000,
  parameter int NB_TIMEOUT      = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
  input  logic                           i_rx_done,
  input  logic [N_DATA-1:0]              i_alu_result,
  input  logic                           i_tx_done,
  output logic [N_DATA-1:0]              o_alu_a,
  output logic [N_DATA-1:0]              o_alu_b,
  output logic [N_OP-1:0]                o_alu_op,
  output logic [N_DATA-1:0]              o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_busy,
  output logic                           o_err,
  output logic [1:0]                     o_err_code
);

  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_e;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;
  // The counter holds the number of idle cycles already seen; the next idle cycle is the last allowed.
  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(N_TIMEOUT - 2);

  state_e                  state_q;
  logic [NB_TIMEOUT-1:0]   cnt_q;
  logic [N_DATA-1:0]       a_q, b_q, tx_data_q;
  logic [N_OP-1:0]         op_q;
  logic                    tx_start_q, err_q;
  logic [1:0]              err_code_q;

  logic [N_DATA-1:0]       rx_byte;
  logic                    parity_ok;
  logic                    busy;

  assign rx_byte   = i_rx_data[N_DATA-1:0];
  assign parity_ok = (PARITY_CHECK == 0) || ((^i_rx_data) == (EVEN_ODD_PARITY != 0));
  assign busy      = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_WAIT_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        S_WAIT_A: begin
          if (i_rx_done) begin
            cnt_q <= '0;
            if (parity_ok) begin
              a_q     <= rx_byte;
              state_q <= S_WAIT_B;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_PARITY;
            end
          end
        end
        S_WAIT_B, S_WAIT_OP: begin
          if (i_rx_done) begin
            cnt_q <= '0;
            if (!parity_ok) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_PARITY;
              state_q    <= S_WAIT_A;
            end else if (state_q == S_WAIT_B) begin
              b_q     <= rx_byte;
              state_q <= S_WAIT_OP;
            end else begin
              op_q    <= rx_byte[N_OP-1:0];
              state_q <= S_EXEC;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_WAIT_A;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            state_q <= S_WAIT_A;
          end
        end
        default: begin
          state_q <= S_WAIT_A;
        end
      endcase
      // A byte arriving while a command is in flight is dropped without disturbing the transfer.
      if (i_rx_done && busy) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_OVERRUN;
      end
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - self-checking bench for uart_alu_ctrl with a command-level reference model.
module tb_uart_alu_ctrl;

  localparam int N_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_err;
  logic [1:0] o_err_code;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_stub(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    return (op == 6'h20) ? a + b : a - b;
  endfunction

  assign alu_result = alu_stub(o_alu_a, o_alu_b, o_alu_op);

  uart_alu_ctrl #(
    .N_DATA(8), .PARITY_CHECK(1), .EVEN_ODD_PARITY(1), .N_OP(6),
    .N_TIMEOUT(N_TIMEOUT), .NB_TIMEOUT(5)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_result(alu_result), .i_tx_done(tx_done),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes collected so far, idle cycles since the last byte, and the
  // post-command phase (1 = compute, 2 = start sent, 3 = awaiting transmitter).
  logic [7:0] m_a, m_b, m_tx_data;
  logic [5:0] m_op;
  logic       m_start, m_err;
  logic [1:0] m_code;
  int         m_n, m_idle, m_phase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx_data = 0;
      m_start = 0; m_err = 0; m_code = 0;
      m_n = 0; m_idle = 0; m_phase = 0;
    end else begin
      m_err = 0;
      m_start = 0;
      if (m_phase != 0) begin
        if (rx_done) begin
          m_err = 1; m_code = 2'd3;
        end
        if (m_phase == 1) begin
          m_tx_data = alu_stub(m_a, m_b, m_op);
          m_start = 1;
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_phase = 3;
        end else if (tx_done) begin
          m_phase = 0;
        end
      end else if (rx_done) begin
        m_idle = 0;
        if ($countones(rx_data) % 2 == 1) begin
          if (m_n == 0) m_a = rx_data[7:0];
          else if (m_n == 1) m_b = rx_data[7:0];
          else m_op = rx_data[5:0];
          m_n++;
          if (m_n == 3) begin
            m_n = 0;
            m_phase = 1;
          end
        end else begin
          m_err = 1; m_code = 2'd1; m_n = 0;
        end
      end else if (m_n > 0) begin
        m_idle++;
        if (m_idle == N_TIMEOUT - 1) begin
          m_err = 1; m_code = 2'd2; m_n = 0; m_idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_a",    32'(o_alu_a),    32'(m_a));
      chk("alu_b",    32'(o_alu_b),    32'(m_b));
      chk("alu_op",   32'(o_alu_op),   32'(m_op));
      chk("tx_data",  32'(o_tx_data),  32'(m_tx_data));
      chk("tx_start", 32'(o_tx_start), 32'(m_start));
      chk("busy",     32'(o_busy),     32'(m_phase != 0));
      chk("err",      32'(o_err),      32'(m_err));
      chk("err_code", 32'(o_err_code), 32'(m_code));
    end
  end

  task automatic send_byte(input logic [8:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    idle(2);
    chk("reset_busy",     32'(o_busy),     32'd0);
    chk("reset_tx_data",  32'(o_tx_data),  32'd0);
    chk("reset_err_code", 32'(o_err_code), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: basic command 5 + 3
    send_byte(9'h105); send_byte(9'h103); send_byte(9'h020);
    chk("t1_a",  32'(o_alu_a),  32'h05);
    chk("t1_b",  32'(o_alu_b),  32'h03);
    chk("t1_op", 32'(o_alu_op), 32'h20);
    chk("t1_busy_exec", 32'(o_busy), 32'd1);
    idle(1);
    chk("t1_start",   32'(o_tx_start), 32'd1);
    chk("t1_tx_data", 32'(o_tx_data),  32'h08);
    idle(2);
    pulse_tx_done();
    chk("t1_idle_busy", 32'(o_busy), 32'd0);
    pulse_tx_done();

    // 2: parity error on B, then a clean 7 + 1
    send_byte(9'h105); send_byte(9'h003);
    chk("t2_err",  32'(o_err),      32'd1);
    chk("t2_code", 32'(o_err_code), 32'd1);
    send_byte(9'h007); send_byte(9'h001); send_byte(9'h020);
    idle(1);
    chk("t2_tx_data", 32'(o_tx_data), 32'h08);
    idle(1);
    pulse_tx_done();

    // 3: timeout after the 19th idle cycle in S_WAIT_B
    send_byte(9'h105);
    idle(18);
    chk("t3_no_err_yet", 32'(o_err), 32'd0);
    idle(1);
    chk("t3_err",  32'(o_err),      32'd1);
    chk("t3_code", 32'(o_err_code), 32'd2);
    send_byte(9'h103);
    chk("t3_new_a", 32'(o_alu_a), 32'h03);

    // 4: byte arriving on the last allowed cycle wins over the timeout; upper opcode bits ignored
    idle(18);
    send_byte(9'h004);
    chk("t4_no_err", 32'(o_err),   32'd0);
    chk("t4_b",      32'(o_alu_b), 32'h04);
    send_byte(9'h0E0);
    chk("t4_op", 32'(o_alu_op), 32'h20);
    idle(1);
    chk("t4_tx_data", 32'(o_tx_data), 32'h07);
    idle(1);
    pulse_tx_done();

    // 5: overrun while waiting on the transmitter
    send_byte(9'h105); send_byte(9'h103); send_byte(9'h020);
    idle(2);
    send_byte(9'h111);
    chk("t5_err",      32'(o_err),      32'd1);
    chk("t5_code",     32'(o_err_code), 32'd3);
    chk("t5_tx_data",  32'(o_tx_data),  32'h08);
    chk("t5_busy",     32'(o_busy),     32'd1);
    idle(3);
    chk("t5_no_start", 32'(o_tx_start), 32'd0);
    pulse_tx_done();
    chk("t5_done", 32'(o_busy), 32'd0);

    // 6: asynchronous reset in S_WAIT_OP
    send_byte(9'h105); send_byte(9'h103);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_a",  32'(o_alu_a),  32'd0);
    chk("t6_b",  32'(o_alu_b),  32'd0);
    chk("t6_op", 32'(o_alu_op), 32'd0);
    chk("t6_outs", 32'({o_tx_data, o_tx_start, o_busy, o_err, o_err_code}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_byte(9'h002);
    chk("t6_first_is_a", 32'(o_alu_a), 32'h02);
    chk("t6_b_clear",    32'(o_alu_b), 32'h00);
    send_byte(9'h001); send_byte(9'h020);
    idle(1);
    chk("t6_tx_data", 32'(o_tx_data), 32'h03);
    idle(1);
    pulse_tx_done();

    // Non-add opcode: stub subtracts, 7 - 2
    send_byte(9'h007); send_byte(9'h002); send_byte(9'h001);
    idle(1);
    chk("sub_tx_data", 32'(o_tx_data), 32'h05);
    idle(1);
    pulse_tx_done();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
